// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath select codes and the ALUOp handoff to the ALU decoder.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:     imm_src = IMM_S;
         OP_BRANCH: imm_src = IMM_B;
         default:   imm_src = IMM_I;
      endcase
   endfunction

   function automatic logic is_supported(input logic [6:0] op);
      is_supported = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                     (op == OP_ITYPE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction function bits to the
// 3-bit ALUControl code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_t      i_alu_op,
   input  logic [2:0]  i_funct3,
   input  logic        i_funct7b5,
   input  logic        i_op5,
   output logic [2:0]  o_alu_control
);

   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_alu_op)
         ALUOP_SUB: o_alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // funct7b5 only selects sub for R-type; for addi it is immediate data
               3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_alu_control = ALU_SLT;
               3'b110:  o_alu_control = ALU_OR;
               3'b111:  o_alu_control = ALU_AND;
               default: o_alu_control = ALU_ADD;
            endcase
         end
         default: o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives every datapath select and strobe.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit WAIT_MEM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [2:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic        illegal_instr,
   output logic        instr_done,
   output logic [3:0]  dbg_state
);

   state_t r_state;
   aluop_t w_alu_op;
   logic   w_ready;
   logic   w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_illegal, w_done;

   assign w_ready = WAIT_MEM ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
      end else begin
         case (r_state)
            FETCH:    if (w_ready) r_state <= DECODE;
            DECODE: begin
               case (op)
                  OP_LW, OP_SW: r_state <= MEMADR;
                  OP_RTYPE:     r_state <= EXECUTER;
                  OP_ITYPE:     r_state <= EXECUTEI;
                  OP_BRANCH:    r_state <= BEQ;
                  default:      r_state <= FETCH;
               endcase
            end
            MEMADR:   r_state <= op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (w_ready) r_state <= MEMWB;
            MEMWRITE: if (w_ready) r_state <= FETCH;
            EXECUTER, EXECUTEI: r_state <= ALUWB;
            default:  r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RS2;
      w_alu_op    = ALUOP_ADD;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_illegal   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         FETCH: begin
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            w_ir_write = w_ready;
            w_pc_write = w_ready;
         end
         DECODE: begin
            // branch target precomputed from OldPC while the opcode is examined
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_IMM;
            w_illegal = !is_supported(op);
         end
         MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         MEMREAD: AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc   = RES_DATA;
            w_reg_write = 1'b1;
            w_done      = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc      = 1'b1;
            w_mem_write = 1'b1;
            w_done      = w_ready;
         end
         EXECUTER: begin
            ALUSrcA  = SRCA_RS1;
            w_alu_op = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            w_alu_op = ALUOP_FUNCT;
         end
         ALUWB: begin
            w_reg_write = 1'b1;
            w_done      = 1'b1;
         end
         BEQ: begin
            // funct3[0] inverts the sense of zero, giving bne
            ALUSrcA    = SRCA_RS1;
            w_alu_op   = ALUOP_SUB;
            w_pc_write = zero ^ funct3[0];
            w_done     = 1'b1;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .i_alu_op      (w_alu_op),
      .i_funct3      (funct3),
      .i_funct7b5    (funct7b5),
      .i_op5         (op[5]),
      .o_alu_control (ALUControl)
   );

   // strobes drop asynchronously with reset, not one edge later
   assign PCWrite       = w_pc_write  & rst_n;
   assign IRWrite       = w_ir_write  & rst_n;
   assign MemWrite      = w_mem_write & rst_n;
   assign RegWrite      = w_reg_write & rst_n;
   assign illegal_instr = w_illegal   & rst_n;
   assign instr_done    = w_done      & rst_n;
   assign ImmSrc        = imm_src(op);
   assign dbg_state     = r_state;

endmodule
